spi_cmd_ram_ai: RTL and testbench
=================================

Name: spi_cmd_ram_ai

Overview:
- Parametrised command-decoded single-port synchronous RAM sitting behind the SPI slave receive/transmit datapath.
- Decodes a 2-bit opcode plus data field from each received word: set write address, write data, set read address, read data.
- Over the fixed 8-bit/256-deep generation it adds: generic data/address width and depth, optional address auto-increment for burst transfers, address range checking with a sticky error flag, and a defined wrap-around.

Parameters:
- DATA_W, 8, RAM word width and width of the command data field.
- ADDR_W, 8, address pointer width; must satisfy ADDR_W <= DATA_W.
- MEM_DEPTH, 256, number of RAM words; must satisfy 1 <= MEM_DEPTH <= 2**ADDR_W.

Ports:
- clk  input  1  clock, all logic on rising edge.
- rst_n  input  1  synchronous active-low reset.
- din  input  DATA_W+2  command word: din[DATA_W+1:DATA_W] opcode, din[DATA_W-1:0] payload.
- rx_valid  input  1  din valid this cycle; one command consumed per cycle when high.
- auto_inc  input  1  when high, write/read data commands post-increment their pointer.
- err_clr  input  1  clears addr_err.
- dout  output  DATA_W  read data.
- tx_valid  output  1  one-cycle pulse marking dout valid.
- addr_err  output  1  sticky: an out-of-range address command was rejected.

Behaviour:
- Reset: rst_n is synchronous and active-low on clk. While rst_n=0 at a rising edge: dout=0, tx_valid=0, addr_err=0, wr_ptr=0, rd_ptr=0. RAM contents are not reset. Reset overrides any rx_valid command in the same cycle.
- Opcodes are ignored when rx_valid=0. When rx_valid=1:
- 00 SET_WA: if the payload is < MEM_DEPTH, wr_ptr <= payload[ADDR_W-1:0]. Otherwise wr_ptr is unchanged and addr_err <= 1.
- 01 WRITE: RAM[wr_ptr] <= payload. If auto_inc=1, wr_ptr <= (wr_ptr==MEM_DEPTH-1) ? 0 : wr_ptr+1.
- 10 SET_RA: same range rule as SET_WA, applied to rd_ptr.
- 11 READ: dout <= RAM[rd_ptr] on that edge, and tx_valid=1 for exactly the following cycle. If auto_inc=1, rd_ptr post-increments with the same wrap rule.
- Range rule: a payload is out of range when any bit above ADDR_W-1 is set, or when its value is >= MEM_DEPTH.
- tx_valid is 0 in every cycle not immediately following an accepted READ. Back-to-back READs hold tx_valid high continuously, with dout updating each cycle.
- dout holds its last value until the next READ. Non-read commands never change dout.
- Read latency: 1 clk from the rx_valid edge to dout/tx_valid.
- Write pointer and read pointer are independent. A WRITE followed by a READ of the same address returns the new data, because the write completes before the read edge.
- Error flag: addr_err is cleared by err_clr=1. If err_clr and a new range error occur in the same cycle, set wins (addr_err=1).
- auto_inc is sampled per command. Changing it mid-burst affects only subsequent commands.
- RAM is inferable as single-port block RAM. Exactly one RAM access per cycle by construction.

Test Plan:
- Reset, then SET_WA 0x10, WRITE 0xA5, SET_RA 0x10, READ -> dout=0xA5, tx_valid high exactly 1 cycle, one cycle after the READ.
- auto_inc=1, SET_WA 0xFE, WRITE 0x11, 0x22, 0x33; SET_RA 0xFE, READ x3 -> dout sequence 0x11, 0x22, 0x33; the third read comes from address 0x00 (wrap); tx_valid high 3 consecutive cycles.
- MEM_DEPTH=200: SET_WA 0xC8 -> addr_err=1, wr_ptr unchanged (following WRITE lands at the old pointer). err_clr pulse -> addr_err=0. err_clr together with SET_RA 0xFF -> addr_err=1.
- auto_inc=0, SET_RA 0x05, READ x2 -> same data both times, rd_ptr stays 0x05. rx_valid=0 with opcode 11 on din -> no tx_valid, dout unchanged.
- Assert rst_n=0 in the same cycle as a READ with rx_valid=1 -> tx_valid=0 and dout=0 the next cycle. Earlier written RAM data is still readable after reset.
- DATA_W=16, ADDR_W=10, MEM_DEPTH=1024: write 0xBEEF at 0x3FF, read it back -> dout=0xBEEF. SET_WA with payload 0x0400 -> addr_err=1.

Source files
------------

// File: rtl/spi_cmd_ram_ai.sv
// Command-decoded single-port RAM behind an SPI slave datapath.
// Each received word carries a 2-bit opcode and a DATA_W-bit payload.
module spi_cmd_ram_ai #(
  parameter int DATA_W    = 8,
  parameter int ADDR_W    = 8,
  parameter int MEM_DEPTH = 256
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W+1:0] din,
  input  logic              rx_valid,
  input  logic              auto_inc,
  input  logic              err_clr,
  output logic [DATA_W-1:0] dout,
  output logic              tx_valid,
  output logic              addr_err
);

  // Handshake: rx_valid qualifies din with no backpressure, so one command is
  // consumed on every rising edge where rx_valid=1. tx_valid is a one-cycle
  // pulse in the cycle after an accepted READ and marks dout as fresh.

  typedef enum logic [1:0] {
    OP_SET_WA = 2'b00,
    OP_WRITE  = 2'b01,
    OP_SET_RA = 2'b10,
    OP_READ   = 2'b11
  } op_e;

  localparam logic [DATA_W:0]   DEPTH_EXT = (DATA_W+1)'(MEM_DEPTH);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(MEM_DEPTH - 1);

  logic [DATA_W-1:0] mem [MEM_DEPTH];

  op_e               op;
  logic [DATA_W-1:0] payload;
  logic [ADDR_W-1:0] payload_addr;
  logic              payload_ok;

  logic [ADDR_W-1:0] wr_ptr;
  logic [ADDR_W-1:0] rd_ptr;
  logic [ADDR_W-1:0] wr_ptr_inc;
  logic [ADDR_W-1:0] rd_ptr_inc;

  logic cmd_set_wa;
  logic cmd_write;
  logic cmd_set_ra;
  logic cmd_read;
  logic range_err;

  assign op           = op_e'(din[DATA_W+1:DATA_W]);
  assign payload      = din[DATA_W-1:0];
  assign payload_addr = payload[ADDR_W-1:0];

  // Since MEM_DEPTH <= 2**ADDR_W, a value compare also rejects any payload
  // with bits set above ADDR_W-1; the extra bit keeps MEM_DEPTH=2**DATA_W exact.
  assign payload_ok = ({1'b0, payload} < DEPTH_EXT);

  assign wr_ptr_inc = (wr_ptr == LAST_ADDR) ? '0 : wr_ptr + ADDR_W'(1);
  assign rd_ptr_inc = (rd_ptr == LAST_ADDR) ? '0 : rd_ptr + ADDR_W'(1);

  always_comb begin
    cmd_set_wa = 1'b0;
    cmd_write  = 1'b0;
    cmd_set_ra = 1'b0;
    cmd_read   = 1'b0;
    if (rx_valid) begin
      case (op)
        OP_SET_WA: cmd_set_wa = 1'b1;
        OP_WRITE:  cmd_write  = 1'b1;
        OP_SET_RA: cmd_set_ra = 1'b1;
        OP_READ:   cmd_read   = 1'b1;
        default:   cmd_read   = 1'b0;
      endcase
    end
    range_err = (cmd_set_wa | cmd_set_ra) & ~payload_ok;
  end

  // RAM write port; reset suppresses a command arriving in the same cycle.
  always_ff @(posedge clk) begin
    if (rst_n && cmd_write) begin
      mem[wr_ptr] <= payload;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      dout     <= '0;
      tx_valid <= 1'b0;
      addr_err <= 1'b0;
    end else begin
      tx_valid <= cmd_read;

      if (cmd_set_wa && payload_ok) begin
        wr_ptr <= payload_addr;
      end else if (cmd_write && auto_inc) begin
        wr_ptr <= wr_ptr_inc;
      end

      if (cmd_set_ra && payload_ok) begin
        rd_ptr <= payload_addr;
      end else if (cmd_read && auto_inc) begin
        rd_ptr <= rd_ptr_inc;
      end

      if (cmd_read) begin
        dout <= mem[rd_ptr];
      end

      // A new range error wins over a simultaneous clear.
      if (range_err) begin
        addr_err <= 1'b1;
      end else if (err_clr) begin
        addr_err <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_spi_cmd_ram_ai.sv
// Directed bench for spi_cmd_ram_ai: default 8/8/256, a 200-deep variant and a
// 16-bit/1024-deep variant, each checked against hand-computed values.
module tb_spi_cmd_ram_ai;

  logic clk;
  logic rst_n;

  // Shared stimulus for the two 8-bit instances.
  logic [9:0]  din8;
  logic        rx8, ai8, ec8;
  logic [7:0]  dout_a, dout_b;
  logic        txv_a, txv_b, err_a, err_b;

  logic [17:0] din16;
  logic        rx16, ai16, ec16;
  logic [15:0] dout_c;
  logic        txv_c, err_c;

  int checks;
  int errors;

  spi_cmd_ram_ai #(.DATA_W(8), .ADDR_W(8), .MEM_DEPTH(256)) u_dut (
    .clk(clk), .rst_n(rst_n), .din(din8), .rx_valid(rx8), .auto_inc(ai8),
    .err_clr(ec8), .dout(dout_a), .tx_valid(txv_a), .addr_err(err_a)
  );

  spi_cmd_ram_ai #(.DATA_W(8), .ADDR_W(8), .MEM_DEPTH(200)) u_d200 (
    .clk(clk), .rst_n(rst_n), .din(din8), .rx_valid(rx8), .auto_inc(ai8),
    .err_clr(ec8), .dout(dout_b), .tx_valid(txv_b), .addr_err(err_b)
  );

  spi_cmd_ram_ai #(.DATA_W(16), .ADDR_W(10), .MEM_DEPTH(1024)) u_w16 (
    .clk(clk), .rst_n(rst_n), .din(din16), .rx_valid(rx16), .auto_inc(ai16),
    .err_clr(ec16), .dout(dout_c), .tx_valid(txv_c), .addr_err(err_c)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  // Called #1 after an edge; returns #1 after the edge that consumed the command.
  task automatic cmd8(input logic [1:0] op, input logic [7:0] pl);
    din8 = {op, pl};
    rx8  = 1'b1;
    @(posedge clk);
    #1;
    rx8  = 1'b0;
  endtask

  task automatic cmd16(input logic [1:0] op, input logic [15:0] pl);
    din16 = {op, pl};
    rx16  = 1'b1;
    @(posedge clk);
    #1;
    rx16  = 1'b0;
  endtask

  task automatic idle();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) idle();
    checks++; if (dout_a !== 8'h00) begin errors++; $display("FAIL reset_dout_a got %h exp 00", dout_a); end
    checks++; if (txv_a !== 1'b0) begin errors++; $display("FAIL reset_txv_a got %b exp 0", txv_a); end
    checks++; if (err_a !== 1'b0) begin errors++; $display("FAIL reset_err_a got %b exp 0", err_a); end
    checks++; if (err_b !== 1'b0) begin errors++; $display("FAIL reset_err_b got %b exp 0", err_b); end
    checks++; if (dout_c !== 16'h0000) begin errors++; $display("FAIL reset_dout_c got %h exp 0000", dout_c); end
    rst_n = 1'b1;
    idle();
  endtask

  task automatic test_basic();
    ai8 = 1'b0;
    cmd8(2'b00, 8'h10);
    cmd8(2'b01, 8'hA5);
    cmd8(2'b10, 8'h10);
    checks++; if (txv_a !== 1'b0) begin errors++; $display("FAIL basic_txv_before got %b exp 0", txv_a); end
    cmd8(2'b11, 8'h00);
    checks++; if (txv_a !== 1'b1) begin errors++; $display("FAIL basic_txv got %b exp 1", txv_a); end
    checks++; if (dout_a !== 8'hA5) begin errors++; $display("FAIL basic_dout got %h exp a5", dout_a); end
    idle();
    checks++; if (txv_a !== 1'b0) begin errors++; $display("FAIL basic_txv_pulse got %b exp 0", txv_a); end
    checks++; if (dout_a !== 8'hA5) begin errors++; $display("FAIL basic_dout_hold got %h exp a5", dout_a); end
  endtask

  task automatic test_burst_wrap();
    logic [7:0] exp_d [3];
    exp_d[0] = 8'h11; exp_d[1] = 8'h22; exp_d[2] = 8'h33;
    ai8 = 1'b1;
    cmd8(2'b00, 8'hFE);
    for (int i = 0; i < 3; i++) cmd8(2'b01, exp_d[i]);
    cmd8(2'b10, 8'hFE);
    for (int i = 0; i < 3; i++) begin
      cmd8(2'b11, 8'h00);
      checks++; if (txv_a !== 1'b1) begin errors++; $display("FAIL burst_txv[%0d] got %b exp 1", i, txv_a); end
      checks++; if (dout_a !== exp_d[i]) begin errors++; $display("FAIL burst_dout[%0d] got %h exp %h", i, dout_a, exp_d[i]); end
    end
    ai8 = 1'b0;
    idle();
    checks++; if (txv_a !== 1'b0) begin errors++; $display("FAIL burst_txv_end got %b exp 0", txv_a); end
  endtask

  task automatic test_no_inc();
    ai8 = 1'b0;
    cmd8(2'b00, 8'h05);
    cmd8(2'b01, 8'h5C);
    cmd8(2'b10, 8'h05);
    cmd8(2'b11, 8'h00);
    checks++; if (dout_a !== 8'h5C) begin errors++; $display("FAIL noinc_rd1 got %h exp 5c", dout_a); end
    cmd8(2'b11, 8'h00);
    checks++; if (dout_a !== 8'h5C) begin errors++; $display("FAIL noinc_rd2 got %h exp 5c", dout_a); end
    din8 = {2'b11, 8'h00};
    rx8  = 1'b0;
    idle();
    checks++; if (txv_a !== 1'b0) begin errors++; $display("FAIL novalid_txv got %b exp 0", txv_a); end
    checks++; if (dout_a !== 8'h5C) begin errors++; $display("FAIL novalid_dout got %h exp 5c", dout_a); end
    cmd8(2'b01, 8'h5D);
    cmd8(2'b11, 8'h00);
    checks++; if (dout_a !== 8'h5D) begin errors++; $display("FAIL noinc_ptrs got %h exp 5d", dout_a); end
  endtask

  task automatic test_range();
    ai8 = 1'b0;
    ec8 = 1'b1; idle(); ec8 = 1'b0;
    checks++; if (err_b !== 1'b0) begin errors++; $display("FAIL range_clr0 got %b exp 0", err_b); end
    cmd8(2'b00, 8'h20);
    cmd8(2'b01, 8'h77);
    cmd8(2'b00, 8'hC8);
    checks++; if (err_b !== 1'b1) begin errors++; $display("FAIL range_err_c8 got %b exp 1", err_b); end
    checks++; if (err_a !== 1'b0) begin errors++; $display("FAIL range_err_full got %b exp 0", err_a); end
    cmd8(2'b01, 8'h88);
    cmd8(2'b10, 8'h20);
    cmd8(2'b11, 8'h00);
    checks++; if (dout_b !== 8'h88) begin errors++; $display("FAIL range_wa_kept got %h exp 88", dout_b); end
    ec8 = 1'b1; idle(); ec8 = 1'b0;
    checks++; if (err_b !== 1'b0) begin errors++; $display("FAIL range_clr got %b exp 0", err_b); end
    cmd8(2'b00, 8'hC7);
    ai8 = 1'b1;
    cmd8(2'b01, 8'h99);
    cmd8(2'b01, 8'hAA);
    ai8 = 1'b0;
    cmd8(2'b10, 8'hC7);
    checks++; if (err_b !== 1'b0) begin errors++; $display("FAIL range_last_ok got %b exp 0", err_b); end
    cmd8(2'b11, 8'h00);
    checks++; if (dout_b !== 8'h99) begin errors++; $display("FAIL range_rd_last got %h exp 99", dout_b); end
    ec8 = 1'b1;
    cmd8(2'b10, 8'hFF);
    ec8 = 1'b0;
    checks++; if (err_b !== 1'b1) begin errors++; $display("FAIL range_set_wins got %b exp 1", err_b); end
    cmd8(2'b11, 8'h00);
    checks++; if (dout_b !== 8'h99) begin errors++; $display("FAIL range_ra_kept got %h exp 99", dout_b); end
    cmd8(2'b10, 8'h00);
    cmd8(2'b11, 8'h00);
    checks++; if (dout_b !== 8'hAA) begin errors++; $display("FAIL range_wrap200 got %h exp aa", dout_b); end
  endtask

  task automatic test_reset_override();
    cmd8(2'b10, 8'h10);
    cmd8(2'b11, 8'h00);
    checks++; if (dout_a !== 8'hA5) begin errors++; $display("FAIL rstov_pre got %h exp a5", dout_a); end
    din8  = {2'b11, 8'h00};
    rx8   = 1'b1;
    rst_n = 1'b0;
    idle();
    rx8   = 1'b0;
    checks++; if (txv_a !== 1'b0) begin errors++; $display("FAIL rstov_txv got %b exp 0", txv_a); end
    checks++; if (dout_a !== 8'h00) begin errors++; $display("FAIL rstov_dout got %h exp 00", dout_a); end
    checks++; if (err_b !== 1'b0) begin errors++; $display("FAIL rstov_err got %b exp 0", err_b); end
    rst_n = 1'b1;
    cmd8(2'b11, 8'h00);
    checks++; if (dout_a !== 8'h33) begin errors++; $display("FAIL rstov_mem0_a got %h exp 33", dout_a); end
    checks++; if (dout_b !== 8'hAA) begin errors++; $display("FAIL rstov_mem0_b got %h exp aa", dout_b); end
    cmd8(2'b10, 8'h10);
    cmd8(2'b11, 8'h00);
    checks++; if (dout_a !== 8'hA5) begin errors++; $display("FAIL rstov_keep got %h exp a5", dout_a); end
  endtask

  task automatic test_wide();
    ai16 = 1'b0;
    cmd16(2'b00, 16'h03FF);
    cmd16(2'b01, 16'hBEEF);
    cmd16(2'b10, 16'h03FF);
    cmd16(2'b11, 16'h0000);
    checks++; if (txv_c !== 1'b1) begin errors++; $display("FAIL wide_txv got %b exp 1", txv_c); end
    checks++; if (dout_c !== 16'hBEEF) begin errors++; $display("FAIL wide_dout got %h exp beef", dout_c); end
    checks++; if (err_c !== 1'b0) begin errors++; $display("FAIL wide_err0 got %b exp 0", err_c); end
    cmd16(2'b00, 16'h0400);
    checks++; if (err_c !== 1'b1) begin errors++; $display("FAIL wide_err got %b exp 1", err_c); end
    cmd16(2'b01, 16'h1234);
    cmd16(2'b11, 16'h0000);
    checks++; if (dout_c !== 16'h1234) begin errors++; $display("FAIL wide_wa_kept got %h exp 1234", dout_c); end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst_n  = 1'b0;
    din8   = '0; rx8  = 1'b0; ai8  = 1'b0; ec8  = 1'b0;
    din16  = '0; rx16 = 1'b0; ai16 = 1'b0; ec16 = 1'b0;
    #1;
    test_reset();
    test_basic();
    test_burst_wrap();
    test_no_inc();
    test_range();
    test_reset_override();
    test_wide();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
